// File: rtl/uart_tx_engine.sv
`timescale 1ns/1ps
// uart_tx_engine
//   One UART transmit channel: a write-side FIFO feeding a serialiser with
//   runtime-selectable word format (5-8 data bits, optional odd/even parity,
//   1 or 2 stop bits), CTS flow control, break generation and a FIFO-level
//   threshold flag.
// Ports
//   wb_clock        : clock, all logic on the rising edge
//   wb_rst_i        : asynchronous active-low reset
//   cfg_divisor     : bit period = cfg_divisor+1 clocks
//   cfg_data_bits   : 00=5, 01=6, 10=7, 11=8 data bits
//   cfg_parity_en   : append a parity bit
//   cfg_parity_even : 1 = even parity, 0 = odd parity
//   cfg_stop2       : two stop bits
//   wr_valid/wr_data/wr_ready : byte write handshake (wr_ready = not full)
//   flush_i         : synchronous FIFO clear (frame in flight continues)
//   cts_i           : clear to send, sampled only when a frame may start
//   brk_i           : hold the line low (break) once the line is idle
//   tx_o            : serial output, idle high
//   busy_o          : a frame or break is in progress
//   fifo_level      : number of bytes held
//   thr_o           : fifo_level <= THRESH
module uart_tx_engine #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16,
  parameter int THRESH     = 4
) (
  input  logic                        wb_clock,
  input  logic                        wb_rst_i,
  input  logic [DIV_WIDTH-1:0]        cfg_divisor,
  input  logic [1:0]                  cfg_data_bits,
  input  logic                        cfg_parity_en,
  input  logic                        cfg_parity_even,
  input  logic                        cfg_stop2,
  input  logic                        wr_valid,
  input  logic [7:0]                  wr_data,
  output logic                        wr_ready,
  input  logic                        flush_i,
  input  logic                        cts_i,
  input  logic                        brk_i,
  output logic                        tx_o,
  output logic                        busy_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        thr_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]     LVL_FULL = FIFO_DEPTH[PTR_W:0];
  localparam logic [PTR_W:0]     LVL_THR  = THRESH[PTR_W:0];
  localparam logic [PTR_W:0]     LVL_ONE  = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0]   PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [DIV_WIDTH-1:0] CNT_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]     r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [PTR_W:0] r_count;

  // Serialiser state, all latched at frame start
  state_t               r_state, w_state_next;
  logic [DIV_WIDTH-1:0] r_cnt, r_div;
  logic [7:0]           r_shift;
  logic [2:0]           r_bit_idx, r_last_idx;
  logic                 r_par_en, r_parity, r_stop_more;
  logic                 r_tx, r_busy;

  logic       w_push, w_pop, w_brk_enter, w_launch, w_tick, w_tx_next;
  logic [7:0] w_head, w_mask;

  assign wr_ready   = (r_count != LVL_FULL);
  assign fifo_level = r_count;
  assign thr_o      = (r_count <= LVL_THR);
  assign tx_o       = r_tx;
  assign busy_o     = r_busy;

  // A push in the same cycle as flush is discarded.
  assign w_push = wr_valid & wr_ready & ~flush_i;
  assign w_head = r_mem[r_rptr];
  // Keep only the configured number of data bits for the parity sum.
  assign w_mask = 8'hFF >> (~cfg_data_bits);
  assign w_tick = (r_cnt == '0);

  // NOTE: FIFO storage has no reset; every location is written before it is
  // read, and leaving it out lets the array map onto plain RAM/regfile cells.
  always_ff @(posedge wb_clock) begin
    if (w_push) r_mem[r_wptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the edge regardless of block order.
  always_ff @(posedge wb_clock or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LVL_ONE;
        2'b01:   r_count <= r_count - LVL_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_brk_enter  = 1'b0;
    w_launch     = 1'b0;
    w_tx_next    = 1'b1;
    case (r_state)
      S_IDLE:  w_launch = 1'b1;
      S_START: begin
        w_tx_next = 1'b0;
        if (w_tick) w_state_next = S_DATA;
      end
      S_DATA: begin
        w_tx_next = r_shift[0];
        if (w_tick && (r_bit_idx == r_last_idx))
          w_state_next = r_par_en ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        w_tx_next = r_parity;
        if (w_tick) w_state_next = S_STOP;
      end
      S_STOP: begin
        // The end of the last stop period makes the same start decision as
        // IDLE, so queued frames follow with no idle gap.
        if (w_tick && !r_stop_more) begin
          w_state_next = S_IDLE;
          w_launch     = 1'b1;
        end
      end
      S_BREAK: begin
        w_tx_next = 1'b0;
        if (!brk_i) w_state_next = S_STOP;
      end
      default: w_state_next = S_IDLE;
    endcase
    if (w_launch) begin
      if (brk_i) begin
        w_state_next = S_BREAK;
        w_brk_enter  = 1'b1;
      end else if ((r_count != '0) && cts_i) begin
        w_state_next = S_START;
        w_pop        = 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clock or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_div       <= '0;
      r_shift     <= '0;
      r_bit_idx   <= '0;
      r_last_idx  <= '0;
      r_par_en    <= 1'b0;
      r_parity    <= 1'b0;
      r_stop_more <= 1'b0;
      r_tx        <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      // Line and busy follow the state one clock later, so every bit
      // period on tx_o is exactly r_div+1 clocks.
      r_tx    <= w_tx_next;
      r_busy  <= (r_state != S_IDLE);

      if (r_state inside {S_START, S_DATA, S_PARITY, S_STOP}) begin
        r_cnt <= w_tick ? r_div : r_cnt - CNT_ONE;
        if (w_tick && (r_state == S_DATA)) begin
          r_shift   <= r_shift >> 1;
          r_bit_idx <= r_bit_idx + 3'd1;
        end
        if (w_tick && (r_state == S_STOP)) r_stop_more <= 1'b0;
      end

      // Break is followed by exactly one stop period.
      if (r_state == S_BREAK) begin
        r_cnt       <= r_div;
        r_stop_more <= 1'b0;
      end
      if (w_brk_enter) r_div <= cfg_divisor;

      if (w_pop) begin
        r_shift     <= w_head;
        r_cnt       <= cfg_divisor;
        r_div       <= cfg_divisor;
        r_bit_idx   <= '0;
        r_last_idx  <= 3'd4 + {1'b0, cfg_data_bits};
        r_par_en    <= cfg_parity_en;
        r_parity    <= (^(w_head & w_mask)) ^ ~cfg_parity_even;
        r_stop_more <= cfg_stop2;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
`timescale 1ns/1ps
module tb_uart_tx_engine;

  logic        wb_clock;
  logic        wb_rst_i;
  logic [15:0] cfg_divisor;
  logic [1:0]  cfg_data_bits;
  logic        cfg_parity_en, cfg_parity_even, cfg_stop2;
  logic        wr_valid;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic        flush_i, cts_i, brk_i;
  logic        tx_o, busy_o, thr_o;
  logic [4:0]  fifo_level;

  uart_tx_engine #(.FIFO_DEPTH(16), .DIV_WIDTH(16), .THRESH(4)) dut (
    .wb_clock        (wb_clock),
    .wb_rst_i        (wb_rst_i),
    .cfg_divisor     (cfg_divisor),
    .cfg_data_bits   (cfg_data_bits),
    .cfg_parity_en   (cfg_parity_en),
    .cfg_parity_even (cfg_parity_even),
    .cfg_stop2       (cfg_stop2),
    .wr_valid        (wr_valid),
    .wr_data         (wr_data),
    .wr_ready        (wr_ready),
    .flush_i         (flush_i),
    .cts_i           (cts_i),
    .brk_i           (brk_i),
    .tx_o            (tx_o),
    .busy_o          (busy_o),
    .fifo_level      (fifo_level),
    .thr_o           (thr_o)
  );

  initial wb_clock = 1'b0;
  always #5 wb_clock = ~wb_clock;

  // Expected line activity: either a whole frame (bit levels in line order)
  // or a break followed by one stop period.
  typedef struct {
    bit        is_brk;
    int        nbits;
    bit [11:0] bits;
    int        div;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_bad    = 0;
  bit   mon_off  = 1'b0;
  bit   mon_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame as it should appear on the wire: start, data LSB first,
  // optional parity, stop bit(s).
  function automatic exp_t make_frame(input logic [7:0] d, input logic [1:0] db,
                                      input logic pe, input logic pv, input logic s2,
                                      input int dv);
    exp_t e;
    int   n, k, ones;
    bit   odd;
    e.is_brk = 1'b0;
    e.div    = dv;
    e.bits   = '0;
    n        = 5 + int'(db);
    ones     = 0;
    e.bits[0] = 1'b0;
    for (int i = 0; i < n; i++) begin
      e.bits[1+i] = d[i];
      if (d[i]) ones++;
    end
    k = 1 + n;
    if (pe) begin
      odd = ((ones % 2) == 1);
      // Even: parity makes total ones even; odd: makes it odd.
      e.bits[k] = pv ? odd : !odd;
      k++;
    end
    e.bits[k] = 1'b1;
    k++;
    if (s2) begin
      e.bits[k] = 1'b1;
      k++;
    end
    e.nbits = k;
    return e;
  endfunction

  function automatic exp_t make_break(input int dv);
    exp_t e;
    e.is_brk = 1'b1;
    e.nbits  = 0;
    e.bits   = '0;
    e.div    = dv;
    return e;
  endfunction

  task automatic write_byte(input logic [7:0] d);
    int n = 0;
    @(negedge wb_clock);
    while (!wr_ready && n < 1000) begin
      @(negedge wb_clock);
      n++;
    end
    if (n >= 1000) check("wr_ready_timeout", n, 0);
    wr_valid = 1'b1;
    wr_data  = d;
    @(negedge wb_clock);
    wr_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    exp_q.push_back(make_frame(d, cfg_data_bits, cfg_parity_en, cfg_parity_even,
                               cfg_stop2, int'(cfg_divisor)));
    write_byte(d);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(exp_q.size() == 0 && !mon_busy && !busy_o && tx_o === 1'b1) && n < 20000) begin
      @(negedge wb_clock);
      n++;
    end
    check("drain_done", (n < 20000), 1);
    repeat (2) @(negedge wb_clock);
  endtask

  task automatic set_cfg(input int dv, input logic [1:0] db, input logic pe,
                         input logic pv, input logic s2);
    cfg_divisor     = dv[15:0];
    cfg_data_bits   = db;
    cfg_parity_en   = pe;
    cfg_parity_even = pv;
    cfg_stop2       = s2;
  endtask

  // Monitor: whenever the line leaves idle, pop the next expectation and
  // check every clock of every bit period.
  initial begin : monitor
    exp_t it;
    bit   got;
    bit   ok;
    int   lowc;
    forever begin
      @(negedge wb_clock);
      if (!mon_off && wb_rst_i === 1'b1 && tx_o === 1'b0) begin
        mon_busy = 1'b1;
        if (exp_q.size() == 0) begin
          check("unexpected_start", exp_q.size(), 1);
        end else begin
          it = exp_q.pop_front();
          if (it.is_brk) begin
            lowc = 0;
            while (tx_o === 1'b0 && lowc < 5000) begin
              lowc++;
              @(negedge wb_clock);
            end
            check("break_released", tx_o, 1);
            ok  = 1'b1;
            got = 1'b1;
            for (int c = 0; c <= it.div; c++) begin
              if (c > 0) @(negedge wb_clock);
              if (ok && tx_o !== 1'b1) begin
                ok  = 1'b0;
                got = tx_o;
              end
            end
            check("break_stop_bit", got, 1);
          end else begin
            for (int b = 0; b < it.nbits; b++) begin
              ok  = 1'b1;
              got = it.bits[b];
              for (int c = 0; c <= it.div; c++) begin
                if (b > 0 || c > 0) @(negedge wb_clock);
                if (ok && tx_o !== it.bits[b]) begin
                  ok  = 1'b0;
                  got = tx_o;
                end
              end
              check($sformatf("frame_bit%0d", b), got, it.bits[b]);
            end
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : stimulus
    int  cnt;
    bit  seen4, seen5;
    wb_rst_i = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    flush_i  = 1'b0;
    cts_i    = 1'b0;
    brk_i    = 1'b0;
    set_cfg(3, 2'b11, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge wb_clock);
    wb_rst_i = 1'b1;
    @(negedge wb_clock);

    // Reset state
    check("rst_tx", tx_o, 1);
    check("rst_ready", wr_ready, 1);
    check("rst_level", fifo_level, 0);
    check("rst_thr", thr_o, 1);
    check("rst_busy", busy_o, 0);

    // 8N1, divisor 3, 0xA5: latency and busy length
    cts_i = 1'b1;
    send(8'hA5);
    @(negedge wb_clock);
    check("latency_edge1_high", tx_o, 1);
    @(negedge wb_clock);
    check("latency_edge2_low", tx_o, 0);
    cnt = 0;
    while (busy_o && cnt < 1000) begin
      cnt++;
      @(negedge wb_clock);
    end
    check("busy_len_8n1", cnt, 40);
    wait_idle();

    // 7E2 0x03, then 5O1 0xFF
    set_cfg(3, 2'b10, 1'b1, 1'b1, 1'b1);
    send(8'h03);
    wait_idle();
    set_cfg(2, 2'b00, 1'b1, 1'b0, 1'b0);
    send(8'hFF);
    wait_idle();

    // Random formats, two back-to-back frames each
    for (int k = 0; k < 8; k++) begin
      set_cfg(int'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
      send(8'($urandom));
      send(8'($urandom));
      wait_idle();
    end

    // Fill with CTS low: no frame, full, extra write dropped
    set_cfg(1, 2'b11, 1'b0, 1'b0, 1'b0);
    cts_i = 1'b0;
    for (int k = 0; k < 16; k++) send(8'($urandom));
    repeat (20) @(negedge wb_clock);
    check("fill_level", fifo_level, 16);
    check("fill_ready", wr_ready, 0);
    check("fill_thr", thr_o, 0);
    check("fill_no_frame_busy", busy_o, 0);
    check("fill_no_frame_tx", tx_o, 1);
    wr_valid = 1'b1;
    wr_data  = 8'h3C;
    @(negedge wb_clock);
    wr_valid = 1'b0;
    check("full_write_dropped", fifo_level, 16);

    // Release CTS: 16 back-to-back frames, threshold crossing
    cts_i = 1'b1;
    cnt = 0;
    while (!busy_o && cnt < 100) begin
      cnt++;
      @(negedge wb_clock);
    end
    check("b2b_started", busy_o, 1);
    cnt   = 0;
    seen4 = 1'b0;
    seen5 = 1'b0;
    while (busy_o && cnt < 2000) begin
      if (fifo_level == 5 && !seen5) begin
        seen5 = 1'b1;
        check("thr_above", thr_o, 0);
      end
      if (fifo_level == 4 && !seen4) begin
        seen4 = 1'b1;
        check("thr_at_level4", thr_o, 1);
      end
      cnt++;
      @(negedge wb_clock);
    end
    check("b2b_busy_span", cnt, 320);
    check("thr_levels_seen", {seen4, seen5}, 2'b11);
    wait_idle();

    // Break requested mid-frame: frame completes, break, one stop, next pop
    set_cfg(2, 2'b11, 1'b0, 1'b0, 1'b1);
    send(8'($urandom));
    exp_q.push_back(make_break(2));
    send(8'($urandom));
    repeat (10) @(negedge wb_clock);
    brk_i = 1'b1;
    repeat (60) @(negedge wb_clock);
    check("brk_line_low", tx_o, 0);
    check("brk_word_held", fifo_level, 1);
    brk_i = 1'b0;
    wait_idle();

    // Flush during a frame: frame completes, level cleared, push discarded
    set_cfg(3, 2'b11, 1'b0, 1'b0, 1'b0);
    send(8'h96);
    repeat (2) @(negedge wb_clock);
    cts_i = 1'b0;
    write_byte(8'h11);
    write_byte(8'h22);
    check("pre_flush_level", fifo_level, 2);
    flush_i  = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 8'h5A;
    @(negedge wb_clock);
    flush_i  = 1'b0;
    wr_valid = 1'b0;
    check("flush_level", fifo_level, 0);
    check("flush_keeps_frame", busy_o, 1);
    wait_idle();
    check("flush_no_late_word", fifo_level, 0);
    cts_i = 1'b1;

    // Asynchronous reset in the middle of an all-zero data field
    mon_off = 1'b1;
    write_byte(8'h00);
    write_byte(8'h11);
    write_byte(8'h22);
    repeat (12) @(negedge wb_clock);
    check("rst_mid_frame_low", tx_o, 0);
    #2 wb_rst_i = 1'b0;
    #1;
    check("rst_async_tx", tx_o, 1);
    check("rst_async_level", fifo_level, 0);
    check("rst_async_busy", busy_o, 0);
    check("rst_async_ready", wr_ready, 1);
    @(negedge wb_clock);
    wb_rst_i = 1'b1;
    repeat (5) @(negedge wb_clock);
    check("post_rst_idle", tx_o, 1);
    mon_off = 1'b0;

    // Normal operation after reset
    send(8'($urandom));
    wait_idle();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
